// File: rtl/branch_checkpoint_stack_pkg.sv
// -----------------------------------------------------------------------------
// branch_checkpoint_stack_pkg
// Shared sizing constants and packet types for the branch checkpoint stack.
//   DEPTH        checkpoint slots (width of a branch mask)
//   NUM_ALLOC    checkpoint allocations per cycle (dispatch lanes)
//   NUM_RESOLVE  branch resolutions per cycle (complete lanes)
//   ARCH_REGS / PHYS_REGS / PHYS_IDX_W  register file geometry
//   ROB_IDX_W    ROB index width, ADDR_W  PC width
// -----------------------------------------------------------------------------
package branch_checkpoint_stack_pkg;

    localparam int DEPTH       = 4;
    localparam int NUM_ALLOC   = 2;
    localparam int NUM_RESOLVE = 2;
    localparam int ARCH_REGS   = 32;
    localparam int PHYS_REGS   = 64;
    localparam int PHYS_IDX_W  = 6;
    localparam int ROB_IDX_W   = 5;
    localparam int ADDR_W      = 32;

    localparam int MAP_W   = ARCH_REGS * PHYS_IDX_W;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int SLOT_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One bit per checkpoint slot.
    typedef logic [DEPTH-1:0] b_mask_t;

    // Everything a checkpoint must hold to rebuild rename/ROB/fetch state.
    typedef struct packed {
        logic [MAP_W-1:0]     map;
        logic [PHYS_REGS-1:0] free;
        logic [ROB_IDX_W-1:0] rob_tail;
        logic [ADDR_W-1:0]    recovery_pc;
    } checkpoint_packet_t;

    // One completion lane.
    typedef struct packed {
        logic              valid;
        b_mask_t           bits;
        logic              mispred;
        logic              taken;
        logic [ADDR_W-1:0] target;
    } resolve_packet_t;

    function automatic logic [CNT_W-1:0] popcount_mask(input b_mask_t m);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + CNT_W'(m[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/branch_checkpoint_stack_slot_picker.sv
// -----------------------------------------------------------------------------
// bcs_slot_picker
// Priority encoder returning the first N set bits of a free mask, lowest
// index first, each as a one-hot vector.
//   free_i   [WIDTH-1:0]    candidate slots (1 = free)
//   pick_o   [N*WIDTH-1:0]  one-hot pick n at [n*WIDTH +: WIDTH], 0 if none
//   found_o  [N-1:0]        pick n exists
// -----------------------------------------------------------------------------
module bcs_slot_picker #(
    parameter int WIDTH = 4,
    parameter int N     = 2
) (
    input  logic [WIDTH-1:0]   free_i,
    output logic [N*WIDTH-1:0] pick_o,
    output logic [N-1:0]       found_o
);

    logic [WIDTH-1:0] remaining;
    logic [WIDTH-1:0] lowest;

    always_comb begin
        pick_o    = '0;
        found_o   = '0;
        remaining = free_i;
        lowest    = '0;
        for (int n = 0; n < N; n++) begin
            // Isolate the lowest set bit, then strip it for the next pick.
            lowest                   = remaining & (~remaining + WIDTH'(1));
            pick_o[n*WIDTH +: WIDTH] = lowest;
            found_o[n]               = |remaining;
            remaining                = remaining & ~lowest;
        end
    end

endmodule

// File: rtl/branch_checkpoint_stack.sv
// -----------------------------------------------------------------------------
// branch_checkpoint_stack
// Branch checkpoint store between dispatch, complete and recovery fan-out.
// Allocates slots (up to NUM_ALLOC per cycle, in lane order, no gaps), takes
// up to NUM_RESOLVE resolutions per cycle, picks the oldest mispredict and
// presents registered recovery state one cycle after the resolve. Retirement
// frees are folded into every live checkpoint's free list each cycle.
// Ports:
//   clock, reset (async, active low)
//   alloc_*      dispatch side: request/snapshot in, grant/slot/dep out
//   free_slots   registered free-slot count
//   resolve_*    completion lanes
//   retire_free  physical registers freed by retirement this cycle
//   clear_mask   combinational: correctly resolved live slots
//   restore_*, squash_mask  registered recovery outputs
// Optional build macro BRANCH_STACK_PERF_EN adds saturating counters
//   perf_mispredicts, perf_full_stalls, perf_multi_mispred.
// -----------------------------------------------------------------------------
module branch_checkpoint_stack
    import branch_checkpoint_stack_pkg::*;
(
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_ALLOC-1:0]             alloc_req,
    input  logic [NUM_ALLOC*MAP_W-1:0]       alloc_map,
    input  logic [NUM_ALLOC*PHYS_REGS-1:0]   alloc_free,
    input  logic [NUM_ALLOC*ROB_IDX_W-1:0]   alloc_rob_tail,
    input  logic [NUM_ALLOC*ADDR_W-1:0]      alloc_recovery_pc,
    output logic [NUM_ALLOC-1:0]             alloc_gnt,
    output logic [NUM_ALLOC*DEPTH-1:0]       alloc_bit,
    output logic [NUM_ALLOC*DEPTH-1:0]       alloc_dep,
    output logic [CNT_W-1:0]                 free_slots,
    input  logic [NUM_RESOLVE-1:0]           resolve_valid,
    input  logic [NUM_RESOLVE*DEPTH-1:0]     resolve_bit,
    input  logic [NUM_RESOLVE-1:0]           resolve_mispred,
    input  logic [NUM_RESOLVE-1:0]           resolve_taken,
    input  logic [NUM_RESOLVE*ADDR_W-1:0]    resolve_target,
    input  logic [PHYS_REGS-1:0]             retire_free,
    output logic [DEPTH-1:0]                 clear_mask,
    output logic                             restore_valid,
    output logic [ADDR_W-1:0]                restore_pc,
    output logic [ROB_IDX_W-1:0]             restore_rob_tail,
    output logic [PHYS_REGS-1:0]             restore_free,
    output logic [MAP_W-1:0]                 restore_map,
    output logic [DEPTH-1:0]                 squash_mask
`ifdef BRANCH_STACK_PERF_EN
    ,
    output logic [31:0]                      perf_mispredicts,
    output logic [31:0]                      perf_full_stalls,
    output logic [31:0]                      perf_multi_mispred
`endif
);

    // ---------------- state ----------------
    b_mask_t            valid_q, valid_d;
    b_mask_t            dep_q  [DEPTH];
    b_mask_t            dep_d  [DEPTH];
    checkpoint_packet_t ckpt_q [DEPTH];
    checkpoint_packet_t ckpt_d [DEPTH];
    logic [CNT_W-1:0]   free_slots_q, free_slots_d;

    logic               restore_valid_q, restore_valid_d;
    logic [ADDR_W-1:0]  restore_pc_q, restore_pc_d;
    logic [ROB_IDX_W-1:0] restore_rob_q, restore_rob_d;
    logic [PHYS_REGS-1:0] restore_free_q, restore_free_d;
    logic [MAP_W-1:0]   restore_map_q, restore_map_d;
    b_mask_t            squash_mask_q, squash_mask_d;

    // ---------------- resolve lanes ----------------
    resolve_packet_t res [NUM_RESOLVE];

    generate
        for (genvar gi = 0; gi < NUM_RESOLVE; gi++) begin : g_res
            assign res[gi] = '{valid:   resolve_valid[gi],
                               bits:    resolve_bit[gi*DEPTH +: DEPTH],
                               mispred: resolve_mispred[gi],
                               taken:   resolve_taken[gi],
                               target:  resolve_target[gi*ADDR_W +: ADDR_W]};
        end
    endgenerate

    // Slots being squashed by the pending restore are already dead for the
    // purpose of starting a new recovery.
    b_mask_t mis_live;
    b_mask_t clear_c, mis_mask;

    assign mis_live = valid_q & ~(restore_valid_q ? squash_mask_q : b_mask_t'(0));

    always_comb begin
        clear_c  = '0;
        mis_mask = '0;
        for (int r = 0; r < NUM_RESOLVE; r++) begin
            if (res[r].valid) begin
                if (res[r].mispred) mis_mask = mis_mask | (res[r].bits & mis_live);
                else                clear_c  = clear_c  | (res[r].bits & valid_q);
            end
        end
    end

    assign clear_mask = clear_c;

    // ---------------- oldest mispredict ----------------
    // The oldest mispredicting slot is the one that depends on no other
    // mispredicting slot.
    b_mask_t           win_oh;
    logic [SLOT_W-1:0] win_idx;
    logic              win_any;
    logic              win_taken;
    logic [ADDR_W-1:0] win_target;
    b_mask_t           squash_c;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        for (int s = 0; s < DEPTH; s++) begin
            if (mis_mask[s] && ((dep_q[s] & mis_mask) == '0)) begin
                win_oh[s] = 1'b1;
                win_idx   = SLOT_W'(s);
            end
        end
        win_any = |win_oh;

        win_taken  = 1'b0;
        win_target = '0;
        for (int r = 0; r < NUM_RESOLVE; r++) begin
            if (res[r].valid && res[r].mispred && (res[r].bits == win_oh)) begin
                win_taken  = res[r].taken;
                win_target = res[r].target;
            end
        end

        squash_c = '0;
        for (int s = 0; s < DEPTH; s++) begin
            squash_c[s] = win_oh[s] | (valid_q[s] & (|(dep_q[s] & win_oh)));
        end
    end

    // ---------------- allocation ----------------
    logic [NUM_ALLOC*DEPTH-1:0] pick;
    logic [NUM_ALLOC-1:0]       found;
    logic                       alloc_block;
    b_mask_t                    lower_bits;

    bcs_slot_picker #(
        .WIDTH (DEPTH),
        .N     (NUM_ALLOC)
    ) u_picker (
        .free_i  (~valid_q),
        .pick_o  (pick),
        .found_o (found)
    );

    // Held reset also blocks grants so every output reads 0 while asserted.
    assign alloc_block = (|mis_mask) | restore_valid_q | ~reset;

    always_comb begin
        alloc_gnt  = '0;
        alloc_bit  = '0;
        alloc_dep  = '0;
        lower_bits = '0;
        for (int k = 0; k < NUM_ALLOC; k++) begin
            // A lane is granted only when every older lane was granted.
            alloc_gnt[k] = alloc_req[k] & found[k] & ~alloc_block &
                           ((k == 0) ? 1'b1 : alloc_gnt[(k == 0) ? 0 : k-1]);
            if (alloc_gnt[k]) begin
                alloc_bit[k*DEPTH +: DEPTH] = pick[k*DEPTH +: DEPTH];
                alloc_dep[k*DEPTH +: DEPTH] = (valid_q & ~clear_c) | lower_bits;
                lower_bits = lower_bits | pick[k*DEPTH +: DEPTH];
            end
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        valid_d = valid_q;
        for (int s = 0; s < DEPTH; s++) begin
            dep_d[s]  = dep_q[s] & ~clear_c;
            ckpt_d[s] = ckpt_q[s];
            if (valid_q[s]) ckpt_d[s].free = ckpt_q[s].free | retire_free;
            if (clear_c[s]) valid_d[s] = 1'b0;
            if (restore_valid_q) begin
                if (squash_mask_q[s]) valid_d[s] = 1'b0;
                dep_d[s] = dep_d[s] & ~squash_mask_q;
            end
            for (int k = 0; k < NUM_ALLOC; k++) begin
                if (alloc_gnt[k] && alloc_bit[k*DEPTH + s]) begin
                    valid_d[s]            = 1'b1;
                    dep_d[s]              = alloc_dep[k*DEPTH +: DEPTH];
                    ckpt_d[s].map         = alloc_map[k*MAP_W +: MAP_W];
                    ckpt_d[s].free        = alloc_free[k*PHYS_REGS +: PHYS_REGS] | retire_free;
                    ckpt_d[s].rob_tail    = alloc_rob_tail[k*ROB_IDX_W +: ROB_IDX_W];
                    ckpt_d[s].recovery_pc = alloc_recovery_pc[k*ADDR_W +: ADDR_W];
                end
            end
        end
        free_slots_d = popcount_mask(~valid_d);

        restore_valid_d = win_any;
        restore_pc_d    = '0;
        restore_rob_d   = '0;
        restore_free_d  = '0;
        restore_map_d   = '0;
        squash_mask_d   = '0;
        if (win_any) begin
            restore_pc_d   = win_taken ? win_target : ckpt_q[win_idx].recovery_pc;
            restore_rob_d  = ckpt_q[win_idx].rob_tail;
            restore_free_d = ckpt_q[win_idx].free | retire_free;
            restore_map_d  = ckpt_q[win_idx].map;
            squash_mask_d  = squash_c;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q         <= '0;
            free_slots_q    <= CNT_W'(DEPTH);
            restore_valid_q <= 1'b0;
            restore_pc_q    <= '0;
            restore_rob_q   <= '0;
            restore_free_q  <= '0;
            restore_map_q   <= '0;
            squash_mask_q   <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                dep_q[s]  <= '0;
                ckpt_q[s] <= '0;
            end
        end else begin
            valid_q         <= valid_d;
            free_slots_q    <= free_slots_d;
            restore_valid_q <= restore_valid_d;
            restore_pc_q    <= restore_pc_d;
            restore_rob_q   <= restore_rob_d;
            restore_free_q  <= restore_free_d;
            restore_map_q   <= restore_map_d;
            squash_mask_q   <= squash_mask_d;
            for (int s = 0; s < DEPTH; s++) begin
                dep_q[s]  <= dep_d[s];
                ckpt_q[s] <= ckpt_d[s];
            end
        end
    end

    assign free_slots       = free_slots_q;
    assign restore_valid    = restore_valid_q;
    assign restore_pc       = restore_pc_q;
    assign restore_rob_tail = restore_rob_q;
    assign restore_free     = restore_free_q;
    assign restore_map      = restore_map_q;
    assign squash_mask      = squash_mask_q;

`ifdef BRANCH_STACK_PERF_EN
    logic [31:0] perf_mis_q, perf_stall_q, perf_multi_q;
    logic [7:0]  mis_lane_cnt;

    always_comb begin
        mis_lane_cnt = '0;
        for (int r = 0; r < NUM_RESOLVE; r++) begin
            if (res[r].valid && res[r].mispred && ((res[r].bits & mis_live) != '0))
                mis_lane_cnt = mis_lane_cnt + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_mis_q   <= '0;
            perf_stall_q <= '0;
            perf_multi_q <= '0;
        end else begin
            if (win_any && (perf_mis_q != '1))                    perf_mis_q   <= perf_mis_q + 32'd1;
            if (alloc_req[0] && !alloc_gnt[0] && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
            if ((mis_lane_cnt >= 8'd2) && (perf_multi_q != '1))   perf_multi_q <= perf_multi_q + 32'd1;
        end
    end

    assign perf_mispredicts   = perf_mis_q;
    assign perf_full_stalls   = perf_stall_q;
    assign perf_multi_mispred = perf_multi_q;
`endif

`ifndef SYNTHESIS
    logic [NUM_ALLOC-1:0] alloc_req_inc;
    assign alloc_req_inc = alloc_req + NUM_ALLOC'(1);

    // Requests must form a contiguous prefix starting at lane 0.
    a_req_prefix: assert property (@(posedge clock) disable iff (!reset)
        (alloc_req & alloc_req_inc) == '0);

    generate
        for (genvar gi = 0; gi < NUM_RESOLVE; gi++) begin : g_chk
            a_onehot: assert property (@(posedge clock) disable iff (!reset)
                resolve_valid[gi] |-> $onehot(resolve_bit[gi*DEPTH +: DEPTH]));
            for (genvar gj = gi + 1; gj < NUM_RESOLVE; gj++) begin : g_pair
                a_distinct: assert property (@(posedge clock) disable iff (!reset)
                    (resolve_valid[gi] && resolve_valid[gj]) |->
                    ((resolve_bit[gi*DEPTH +: DEPTH] & resolve_bit[gj*DEPTH +: DEPTH]) == '0));
            end
        end
    endgenerate
`endif

endmodule

// File: tb/tb_branch_checkpoint_stack.sv
// -----------------------------------------------------------------------------
// tb_branch_checkpoint_stack
// Directed bench: a table of per-cycle vectors for allocation / correct
// resolve / mispredict masks, then hand-written sequences for recovery data,
// retire-free merging and reset while a restore is pending.
// -----------------------------------------------------------------------------
module tb_branch_checkpoint_stack;
    import branch_checkpoint_stack_pkg::*;

    logic                           clock;
    logic                           reset;
    logic [NUM_ALLOC-1:0]           alloc_req;
    logic [NUM_ALLOC*MAP_W-1:0]     alloc_map;
    logic [NUM_ALLOC*PHYS_REGS-1:0] alloc_free;
    logic [NUM_ALLOC*ROB_IDX_W-1:0] alloc_rob_tail;
    logic [NUM_ALLOC*ADDR_W-1:0]    alloc_recovery_pc;
    logic [NUM_ALLOC-1:0]           alloc_gnt;
    logic [NUM_ALLOC*DEPTH-1:0]     alloc_bit;
    logic [NUM_ALLOC*DEPTH-1:0]     alloc_dep;
    logic [CNT_W-1:0]               free_slots;
    logic [NUM_RESOLVE-1:0]         resolve_valid;
    logic [NUM_RESOLVE*DEPTH-1:0]   resolve_bit;
    logic [NUM_RESOLVE-1:0]         resolve_mispred;
    logic [NUM_RESOLVE-1:0]         resolve_taken;
    logic [NUM_RESOLVE*ADDR_W-1:0]  resolve_target;
    logic [PHYS_REGS-1:0]           retire_free;
    logic [DEPTH-1:0]               clear_mask;
    logic                           restore_valid;
    logic [ADDR_W-1:0]              restore_pc;
    logic [ROB_IDX_W-1:0]           restore_rob_tail;
    logic [PHYS_REGS-1:0]           restore_free;
    logic [MAP_W-1:0]               restore_map;
    logic [DEPTH-1:0]               squash_mask;

    branch_checkpoint_stack dut (
        .clock             (clock),
        .reset             (reset),
        .alloc_req         (alloc_req),
        .alloc_map         (alloc_map),
        .alloc_free        (alloc_free),
        .alloc_rob_tail    (alloc_rob_tail),
        .alloc_recovery_pc (alloc_recovery_pc),
        .alloc_gnt         (alloc_gnt),
        .alloc_bit         (alloc_bit),
        .alloc_dep         (alloc_dep),
        .free_slots        (free_slots),
        .resolve_valid     (resolve_valid),
        .resolve_bit       (resolve_bit),
        .resolve_mispred   (resolve_mispred),
        .resolve_taken     (resolve_taken),
        .resolve_target    (resolve_target),
        .retire_free       (retire_free),
        .clear_mask        (clear_mask),
        .restore_valid     (restore_valid),
        .restore_pc        (restore_pc),
        .restore_rob_tail  (restore_rob_tail),
        .restore_free      (restore_free),
        .restore_map       (restore_map),
        .squash_mask       (squash_mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alloc_req         = '0;
        alloc_map         = '0;
        alloc_free        = '0;
        alloc_rob_tail    = '0;
        alloc_recovery_pc = '0;
        resolve_valid     = '0;
        resolve_bit       = '0;
        resolve_mispred   = '0;
        resolve_taken     = '0;
        resolve_target    = '0;
        retire_free       = '0;
    endtask

    // Returns at posedge+1, a safe point to drive the next cycle's inputs.
    task automatic next_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        next_edge();
        next_edge();
        reset = 1'b1;
        next_edge();
    endtask

    typedef struct {
        logic [1:0] req;
        logic [1:0] rv;
        logic [3:0] rb0;
        logic [3:0] rb1;
        logic [1:0] mis;
        logic [1:0] e_gnt;
        logic [3:0] e_bit0;
        logic [3:0] e_bit1;
        logic [3:0] e_dep0;
        logic [3:0] e_dep1;
        logic [3:0] e_clear;
        logic [2:0] e_free;
        logic       e_rv;
        logic [3:0] e_sq;
    } vec_t;

    vec_t vecs [13];

    localparam logic [MAP_W-1:0] MAPC = {6{32'h1234_5678}};

    initial begin
        //          req    rv     rb0      rb1      mis    gnt    bit0     bit1     dep0     dep1     clear    free  rv    sq
        vecs[0]  = '{2'b11, 2'b00, 4'b0000, 4'b0000, 2'b00, 2'b11, 4'b0001, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 3'd2, 1'b0, 4'b0000};
        vecs[1]  = '{2'b11, 2'b00, 4'b0000, 4'b0000, 2'b00, 2'b11, 4'b0100, 4'b1000, 4'b0011, 4'b0111, 4'b0000, 3'd0, 1'b0, 4'b0000};
        vecs[2]  = '{2'b01, 2'b00, 4'b0000, 4'b0000, 2'b00, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'd0, 1'b0, 4'b0000};
        vecs[3]  = '{2'b01, 2'b01, 4'b0100, 4'b0000, 2'b00, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 3'd1, 1'b0, 4'b0000};
        vecs[4]  = '{2'b01, 2'b00, 4'b0000, 4'b0000, 2'b00, 2'b01, 4'b0100, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 3'd0, 1'b0, 4'b0000};
        vecs[5]  = '{2'b00, 2'b11, 4'b0001, 4'b0010, 2'b00, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 3'd2, 1'b0, 4'b0000};
        vecs[6]  = '{2'b00, 2'b10, 4'b0000, 4'b0010, 2'b00, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'd2, 1'b0, 4'b0000};
        vecs[7]  = '{2'b11, 2'b00, 4'b0000, 4'b0000, 2'b00, 2'b11, 4'b0001, 4'b0010, 4'b1100, 4'b1101, 4'b0000, 3'd0, 1'b0, 4'b0000};
        vecs[8]  = '{2'b11, 2'b11, 4'b1000, 4'b0100, 2'b00, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1100, 3'd2, 1'b0, 4'b0000};
        vecs[9]  = '{2'b11, 2'b00, 4'b0000, 4'b0000, 2'b00, 2'b11, 4'b0100, 4'b1000, 4'b0011, 4'b0111, 4'b0000, 3'd0, 1'b0, 4'b0000};
        vecs[10] = '{2'b00, 2'b11, 4'b0010, 4'b0100, 2'b11, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'd0, 1'b1, 4'b1110};
        vecs[11] = '{2'b01, 2'b00, 4'b0000, 4'b0000, 2'b00, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'd3, 1'b0, 4'b0000};
        vecs[12] = '{2'b11, 2'b00, 4'b0000, 4'b0000, 2'b00, 2'b11, 4'b0010, 4'b0100, 4'b0001, 4'b0011, 4'b0000, 3'd1, 1'b0, 4'b0000};

        reset = 1'b0;
        idle_inputs();
        next_edge();
        // Reset state while held.
        check("rst_free_slots", 256'(free_slots), 256'(DEPTH));
        check("rst_restore_valid", 256'(restore_valid), 256'd0);
        check("rst_squash", 256'(squash_mask), 256'd0);
        check("rst_clear", 256'(clear_mask), 256'd0);
        check("rst_gnt", 256'(alloc_gnt), 256'd0);
        check("rst_restore_pc", 256'(restore_pc), 256'd0);
        reset = 1'b1;
        next_edge();
        $display("[TB] reset state checked");

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 13; i++) begin
            idle_inputs();
            alloc_req             = vecs[i].req;
            resolve_valid         = vecs[i].rv;
            resolve_bit[3:0]      = vecs[i].rb0;
            resolve_bit[7:4]      = vecs[i].rb1;
            resolve_mispred       = vecs[i].mis;
            #3;
            check($sformatf("v%0d_gnt", i), 256'(alloc_gnt), 256'(vecs[i].e_gnt));
            check($sformatf("v%0d_bit0", i), 256'(alloc_bit[3:0]), 256'(vecs[i].e_bit0));
            check($sformatf("v%0d_bit1", i), 256'(alloc_bit[7:4]), 256'(vecs[i].e_bit1));
            check($sformatf("v%0d_dep0", i), 256'(alloc_dep[3:0]), 256'(vecs[i].e_dep0));
            check($sformatf("v%0d_dep1", i), 256'(alloc_dep[7:4]), 256'(vecs[i].e_dep1));
            check($sformatf("v%0d_clear", i), 256'(clear_mask), 256'(vecs[i].e_clear));
            next_edge();
            check($sformatf("v%0d_free_slots", i), 256'(free_slots), 256'(vecs[i].e_free));
            check($sformatf("v%0d_restore_valid", i), 256'(restore_valid), 256'(vecs[i].e_rv));
            check($sformatf("v%0d_squash", i), 256'(squash_mask), 256'(vecs[i].e_sq));
            $display("[TB] vec %0d req=%b rv=%b rb=%b/%b mis=%b gnt=%b clear=%b free=%0d squash=%b",
                     i, vecs[i].req, vecs[i].rv, vecs[i].rb0, vecs[i].rb1, vecs[i].mis,
                     alloc_gnt, clear_mask, free_slots, squash_mask);
        end

        // ---------------- sequence A: restore PC / ROB / map ----------------
        do_reset();
        idle_inputs();
        alloc_req                = 2'b01;
        alloc_recovery_pc[31:0]  = 32'h104;
        alloc_rob_tail[4:0]      = 5'd5;
        alloc_map[MAP_W-1:0]     = MAPC;
        #3;
        check("A_alloc_gnt", 256'(alloc_gnt), 256'b01);
        check("A_alloc_bit", 256'(alloc_bit[3:0]), 256'b0001);
        next_edge();
        idle_inputs();
        alloc_req             = 2'b01;
        resolve_valid         = 2'b01;
        resolve_bit[3:0]      = 4'b0001;
        resolve_mispred       = 2'b01;
        resolve_taken         = 2'b00;
        resolve_target[31:0]  = 32'h999;
        #3;
        check("A_gnt_in_mispredict", 256'(alloc_gnt), 256'd0);
        next_edge();
        check("A_restore_valid", 256'(restore_valid), 256'd1);
        check("A_restore_pc_nt", 256'(restore_pc), 256'h104);
        check("A_restore_rob", 256'(restore_rob_tail), 256'd5);
        check("A_restore_map", 256'(restore_map), 256'(MAPC));
        check("A_squash", 256'(squash_mask), 256'b0001);
        $display("[TB] seqA mispredict not-taken restore_pc=%0h", restore_pc);
        idle_inputs();
        next_edge();
        check("A_restore_drop", 256'(restore_valid), 256'd0);
        check("A_free_after_squash", 256'(free_slots), 256'd4);
        idle_inputs();
        alloc_req               = 2'b01;
        alloc_recovery_pc[31:0] = 32'h104;
        #3;
        check("A_realloc_bit", 256'(alloc_bit[3:0]), 256'b0001);
        next_edge();
        idle_inputs();
        resolve_valid        = 2'b10;
        resolve_bit[7:4]     = 4'b0001;
        resolve_mispred      = 2'b10;
        resolve_taken        = 2'b10;
        resolve_target[63:32] = 32'h200;
        next_edge();
        check("A_restore_pc_taken", 256'(restore_pc), 256'h200);
        $display("[TB] seqA mispredict taken restore_pc=%0h", restore_pc);
        idle_inputs();
        next_edge();

        // ---------------- sequence B: retire frees merged ----------------
        do_reset();
        idle_inputs();
        alloc_req             = 2'b01;
        alloc_free[63:0]      = 64'h1;
        retire_free           = 64'h8;
        next_edge();
        idle_inputs();
        next_edge();
        retire_free = 64'h80;
        next_edge();
        idle_inputs();
        resolve_valid    = 2'b01;
        resolve_bit[3:0] = 4'b0001;
        resolve_mispred  = 2'b01;
        retire_free      = 64'h100;
        next_edge();
        check("B_restore_free", 256'(restore_free), 256'h189);
        $display("[TB] seqB restore_free=%0h", restore_free);
        idle_inputs();
        next_edge();

        // ---------------- sequence C: reset with restore pending ----------------
        do_reset();
        idle_inputs();
        alloc_req = 2'b01;
        next_edge();
        check("C_free_before", 256'(free_slots), 256'd3);
        idle_inputs();
        alloc_req        = 2'b01;
        resolve_valid    = 2'b01;
        resolve_bit[3:0] = 4'b0001;
        resolve_mispred  = 2'b01;
        #1;
        reset = 1'b0;
        #1;
        check("C_async_free_slots", 256'(free_slots), 256'd4);
        check("C_async_gnt", 256'(alloc_gnt), 256'd0);
        check("C_async_clear", 256'(clear_mask), 256'd0);
        next_edge();
        check("C_restore_valid", 256'(restore_valid), 256'd0);
        check("C_restore_pc", 256'(restore_pc), 256'd0);
        check("C_squash", 256'(squash_mask), 256'd0);
        check("C_restore_free", 256'(restore_free), 256'd0);
        idle_inputs();
        #3;
        reset = 1'b1;
        next_edge();
        check("C_after_release_rv", 256'(restore_valid), 256'd0);
        check("C_after_release_free", 256'(free_slots), 256'd4);
        $display("[TB] seqC reset during pending restore, restore_valid=%0d", restore_valid);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/branch_checkpoint_stack.md
Name: branch_checkpoint_stack

Overview:
Parametrised branch checkpoint store between dispatch, complete and the recovery fan-out (fetch, ROB, free list, map table, RS). It allocates checkpoint slots itself and accepts several allocations and several resolutions per cycle. It picks the oldest mispredict among simultaneous resolutions and keeps checkpointed free lists current with retirement frees. Recovery outputs are registered, one cycle after the resolve.

Parameters:
DEPTH, 4, checkpoint slots (B_MASK width)
NUM_ALLOC, 2, branch allocations per cycle
NUM_RESOLVE, 2, branch resolutions per cycle
ARCH_REGS, 32, architectural registers
PHYS_REGS, 64, physical registers
PHYS_IDX_W, 6, physical register index width
ROB_IDX_W, 5, ROB index width
ADDR_W, 32, PC width

Ports:
clock  in  1  clock
reset  in  1  asynchronous active-low reset (asserted at 0)
alloc_req  in  NUM_ALLOC  per-lane checkpoint request, lane 0 oldest
alloc_map  in  NUM_ALLOC*ARCH_REGS*PHYS_IDX_W  map table snapshot per lane
alloc_free  in  NUM_ALLOC*PHYS_REGS  free list snapshot per lane
alloc_rob_tail  in  NUM_ALLOC*ROB_IDX_W  ROB tail per lane
alloc_recovery_pc  in  NUM_ALLOC*ADDR_W  fall-through PC per lane
alloc_gnt  out  NUM_ALLOC  lane granted
alloc_bit  out  NUM_ALLOC*DEPTH  one-hot slot per granted lane
alloc_dep  out  NUM_ALLOC*DEPTH  dependency mask per granted lane
free_slots  out  $clog2(DEPTH+1)  registered free-slot count
resolve_valid  in  NUM_RESOLVE  completion lane valid
resolve_bit  in  NUM_RESOLVE*DEPTH  one-hot slot being resolved
resolve_mispred  in  NUM_RESOLVE  lane mispredicted
resolve_taken  in  NUM_RESOLVE  actual direction
resolve_target  in  NUM_RESOLVE*ADDR_W  computed target
retire_free  in  PHYS_REGS  registers freed by retirement this cycle
clear_mask  out  DEPTH  combinational: correctly resolved slots to clear from masks
restore_valid  out  1  registered recovery strobe
restore_pc  out  ADDR_W  recovery fetch PC
restore_rob_tail  out  ROB_IDX_W  ROB tail
restore_free  out  PHYS_REGS  free list
restore_map  out  ARCH_REGS*PHYS_IDX_W  map table
squash_mask  out  DEPTH  slots killed, valid with restore_valid

Behaviour:
- Reset: all slots free, live mask 0, free_slots=DEPTH, every output 0.
- State per slot: valid, dep mask, map, free list, rob tail, recovery PC.
- Allocation: scan slots from the lowest free index. Lane k is granted only if lanes 0..k-1 requested and were granted and a free slot remains. Grants are in order, with no gaps.
- alloc_dep[k] = live mask minus slots resolved or squashed this cycle, plus alloc_bit of granted lanes below k.
- No grants in a cycle with any valid mispredict resolve or with restore_valid=1.
- A slot freed in cycle t is allocatable in t+1 only.
- Correct resolve of a live slot: slot freed, its bit cleared from every slot's dep mask, bit set in clear_mask the same cycle.
- Mispredict: among valid mispredicting live slots, the winner is the one whose dep mask contains no other mispredicting slot. This is unique for legal input.
- In cycle t+1: restore_valid=1. restore_pc = taken ? target : recovery_pc. Other restore_* outputs come from the winner slot. squash_mask = winner bit plus every slot whose dep mask holds the winner.
- All squashed slots are freed at t+1. Correct resolves of squashed slots in the same cycle are still reported in clear_mask and are harmless.
- Resolves for non-live slots are ignored.
- Each cycle retire_free is ORed into the free list of every live slot and into snapshots being written. restore_free includes the retire_free of the cycle t capture.
- Assertions: one-hot resolve_bit, no two lanes resolving the same slot, alloc_req never exceeding the request prefix.
- Reset while restore is pending: restore dropped, all state cleared asynchronously.

Optional Feature:
BRANCH_STACK_PERF_EN: adds 32-bit saturating counters perf_mispredicts, perf_full_stalls (cycles with alloc_req[0]=1 and no grant) and perf_multi_mispred (cycles with ≥2 mispredicting lanes), exposed as output ports and reset to 0. Without the macro these ports and counters do not exist.

Decomposition:
- Shared package: B_MASK (DEPTH bits), CHECKPOINT_PACKET (map, free, rob_tail, recovery_pc), RESOLVE_PACKET, DEPTH/lane constants.
- Sub-module: bcs_slot_picker, a priority encoder giving the first N free slots, reused for allocation.

Test Plan:
- Two requests on an empty stack -> gnt=2'b11, alloc_bit lane0=0001 lane1=0010, lane1 dep=0001, free_slots=2 next cycle.
- Four slots live, alloc_req=01 -> gnt=0, free_slots=0. Correct resolve of slot 2 -> clear_mask=0100, grant of slot 2 in the following cycle.
- Chain 0←1←2 (slot 2 dep=0011). Mispredict on 1 and 2 the same cycle -> next cycle restore from slot 1, squash_mask=0110, slot 0 still live.
- Mispredict slot 0 with taken=0 and recovery_pc=0x104 -> restore_pc=0x104. Same with taken=1 and target=0x200 -> 0x200. Alloc in the mispredict cycle -> gnt=0.
- Checkpoint free=0, then retire_free bit 7 two cycles later, then mispredict -> restore_free bit 7=1.
- Reset pulled low in the cycle between resolve and restore -> restore_valid stays 0 and all outputs are 0.
